// File: rtl/mem_access_stage_if.sv
// Bundles the execute-side, data-memory and writeback-side signals of the MEM stage.
// No logic and no latency: wires only.
// Backpressure travels on stall (to execute) and dmem_ready (from memory).
interface mem_access_stage_if;
   // execute side
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [1:0]  ex_size;
   logic        ex_unsigned;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        stall;
   // data memory side
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   // writeback side
   logic [31:0] data_out_mem;
   logic [31:0] data_out_alu;
   logic        rw_d;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        wb_valid;
   logic        misalign_err;
   logic        bus_err;

   // stage view
   modport slave (
      input  ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
             ex_size, ex_unsigned, ex_rd, ex_reg_write, dmem_rdata, dmem_ready,
      output stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             data_out_mem, data_out_alu, rw_d, wb_rd, wb_reg_write, wb_valid,
             misalign_err, bus_err
   );

   // environment view (execute + memory + writeback)
   modport master (
      output ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
             ex_size, ex_unsigned, ex_rd, ex_reg_write, dmem_rdata, dmem_ready,
      input  stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             data_out_mem, data_out_alu, rw_d, wb_rd, wb_reg_write, wb_valid,
             misalign_err, bus_err
   );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: aligns loads/stores onto a word-wide data memory and registers writeback inputs.
// Latency: ALU ops and misaligned ops 1 edge; memory ops 2 edges plus memory wait cycles.
// Backpressure: stall is high for every ACCESS cycle; the access aborts after TIMEOUT_CYCLES waits.
module mem_access_stage #(
   parameter int data_width     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   mem_access_stage_if.slave  bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t state, state_nxt;

   // op fields captured on accept, held for the whole access
   logic [data_width-1:0] addr_q;
   logic [data_width-1:0] wdata_q;
   logic                  we_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [4:0]            rd_q;
   logic                  reg_write_q;

   logic [CW-1:0]         wait_cnt, wait_cnt_nxt;
   logic                  accept;

   // next values of the writeback registers
   logic [data_width-1:0] mem_d, alu_d;
   logic                  rw_d_d, reg_write_d, valid_d, misalign_d, bus_err_d;
   logic [4:0]            rd_d;

   logic                  is_mem_op, misaligned;
   logic [data_width-1:0] lane, load_val;

   assign is_mem_op = bus.ex_mem_read | bus.ex_mem_write;

   // illegal size counts as misaligned so it retires as an error too
   assign misaligned = (bus.ex_size == 2'b11) ||
                       (bus.ex_size == 2'b01 && bus.ex_alu_result[0]) ||
                       (bus.ex_size == 2'b10 && bus.ex_alu_result[1:0] != 2'b00);

   // selected lane shifted down to bit 0
   assign lane = bus.dmem_rdata >> {addr_q[1:0], 3'b000};

   // load extension by access size
   always_comb begin
      load_val = lane;
      case (size_q)
         2'b00:   load_val = uns_q ? {24'b0, lane[7:0]}   : {{24{lane[7]}}, lane[7:0]};
         2'b01:   load_val = uns_q ? {16'b0, lane[15:0]}  : {{16{lane[15]}}, lane[15:0]};
         default: load_val = lane;
      endcase
   end

   // memory-side outputs are driven only in ACCESS so they are 0 in reset and idle
   assign bus.stall     = (state == ACCESS);
   assign bus.dmem_req  = (state == ACCESS);
   assign bus.dmem_we   = (state == ACCESS) & we_q;
   assign bus.dmem_addr = (state == ACCESS) ? {addr_q[31:2], 2'b00} : '0;

   // byte enables and lane-replicated store data
   always_comb begin
      bus.dmem_be    = 4'b0000;
      bus.dmem_wdata = '0;
      if (state == ACCESS) begin
         case (size_q)
            2'b00: begin
               bus.dmem_be    = 4'b0001 << addr_q[1:0];
               bus.dmem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
               bus.dmem_be    = 4'b0011 << addr_q[1:0];
               bus.dmem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
               bus.dmem_be    = 4'b1111;
               bus.dmem_wdata = wdata_q;
            end
         endcase
      end
   end

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next state, accept and retirement values
   always_comb begin
      state_nxt    = state;
      accept       = 1'b0;
      wait_cnt_nxt = wait_cnt;
      mem_d        = bus.data_out_mem;
      alu_d        = bus.data_out_alu;
      rw_d_d       = bus.rw_d;
      rd_d         = bus.wb_rd;
      reg_write_d  = 1'b0;
      valid_d      = 1'b0;
      misalign_d   = 1'b0;
      bus_err_d    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ex_valid) begin
               if (!is_mem_op) begin
                  valid_d     = 1'b1;
                  alu_d       = bus.ex_alu_result;
                  rw_d_d      = 1'b0;
                  rd_d        = bus.ex_rd;
                  reg_write_d = bus.ex_reg_write;
               end else if (misaligned) begin
                  valid_d    = 1'b1;
                  misalign_d = 1'b1;
                  alu_d      = bus.ex_alu_result;
                  rw_d_d     = 1'b0;
                  rd_d       = bus.ex_rd;
               end else begin
                  accept       = 1'b1;
                  wait_cnt_nxt = '0;
                  state_nxt    = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (bus.dmem_ready) begin
               // completion wins over a timeout on the same edge
               state_nxt = IDLE;
               valid_d   = 1'b1;
               alu_d     = addr_q;
               rd_d      = rd_q;
               if (we_q) begin
                  rw_d_d = 1'b0;
               end else begin
                  mem_d       = load_val;
                  rw_d_d      = 1'b1;
                  reg_write_d = reg_write_q;
               end
            end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = IDLE;
               valid_d   = 1'b1;
               bus_err_d = 1'b1;
               alu_d     = addr_q;
               rw_d_d    = 1'b0;
               rd_d      = rd_q;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // wait counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) wait_cnt <= '0;
      else          wait_cnt <= wait_cnt_nxt;
   end

   // capture op fields on accept
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
      end else if (accept) begin
         addr_q      <= bus.ex_alu_result;
         wdata_q     <= bus.ex_store_data;
         we_q        <= bus.ex_mem_write;
         size_q      <= bus.ex_size;
         uns_q       <= bus.ex_unsigned;
         rd_q        <= bus.ex_rd;
         reg_write_q <= bus.ex_reg_write;
      end
   end

   // writeback registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.data_out_mem <= '0;
         bus.data_out_alu <= '0;
         bus.rw_d         <= 1'b0;
         bus.wb_rd        <= '0;
         bus.wb_reg_write <= 1'b0;
         bus.wb_valid     <= 1'b0;
         bus.misalign_err <= 1'b0;
         bus.bus_err      <= 1'b0;
      end else begin
         bus.data_out_mem <= mem_d;
         bus.data_out_alu <= alu_d;
         bus.rw_d         <= rw_d_d;
         bus.wb_rd        <= rd_d;
         bus.wb_reg_write <= reg_write_d;
         bus.wb_valid     <= valid_d;
         bus.misalign_err <= misalign_d;
         bus.bus_err      <= bus_err_d;
      end
   end

endmodule
